// File: rtl/lc3_execute.sv
// LC-3 execute stage: ALU (ADD/AND/NOT) and PC-relative address generation with
// operand forwarding from the execute and memory stages; all results registered.
module lc3_execute (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable_execute,
   input  logic [15:0] IR,
   input  logic [15:0] npc_in,
   input  logic [5:0]  E_Control,
   input  logic [1:0]  W_Control_in,
   input  logic [15:0] VSR1,
   input  logic [15:0] VSR2,
   input  logic        bypass_alu_1,
   input  logic        bypass_alu_2,
   input  logic        bypass_mem_1,
   input  logic        bypass_mem_2,
   input  logic [15:0] Mem_Bypass_Val,
   output logic [15:0] aluout,
   output logic [15:0] pcout,
   output logic [1:0]  W_Control_out,
   output logic [2:0]  dr,
   output logic [15:0] M_Data,
   output logic [15:0] IR_Exec,
   output logic [2:0]  sr1,
   output logic [2:0]  sr2
);

   logic [15:0] aluout_q, aluout_d;
   logic [15:0] pcout_q, pcout_d;
   logic [1:0]  wctl_q;
   logic [2:0]  dr_q;
   logic [15:0] mdata_q;
   logic [15:0] ir_q;

   logic [1:0]  alu_control;
   logic [1:0]  pcselect1;
   logic        pcselect2;
   logic        op2select;

   logic [15:0] op1;
   logic [15:0] r2;
   logic [15:0] op2;
   logic [15:0] imm5;
   logic [15:0] offset;
   logic [15:0] base;

   assign alu_control = E_Control[5:4];
   assign pcselect1   = E_Control[3:2];
   assign pcselect2   = E_Control[1];
   assign op2select   = E_Control[0];

   assign sr1 = IR[8:6];
   assign sr2 = IR[2:0];

   assign imm5 = {{11{IR[4]}}, IR[4:0]};

   // ALU forwarding takes priority: it carries the newer result.
   always_comb begin
      op1 = VSR1;
      if (bypass_alu_1)
         op1 = aluout_q;
      else if (bypass_mem_1)
         op1 = Mem_Bypass_Val;

      r2 = VSR2;
      if (bypass_alu_2)
         r2 = aluout_q;
      else if (bypass_mem_2)
         r2 = Mem_Bypass_Val;

      op2 = op2select ? r2 : imm5;
   end

   always_comb begin
      aluout_d = '0;
      case (alu_control)
         2'b00:   aluout_d = op1 + op2;
         2'b01:   aluout_d = op1 & op2;
         2'b10:   aluout_d = ~op1;
         default: aluout_d = '0;
      endcase
   end

   always_comb begin
      offset = '0;
      case (pcselect1)
         2'b00:   offset = {{5{IR[10]}}, IR[10:0]};
         2'b01:   offset = {{7{IR[8]}}, IR[8:0]};
         2'b10:   offset = {{10{IR[5]}}, IR[5:0]};
         default: offset = '0;
      endcase
      base    = pcselect2 ? npc_in : op1;
      pcout_d = base + offset;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         aluout_q <= '0;
         pcout_q  <= '0;
         wctl_q   <= '0;
         dr_q     <= '0;
         mdata_q  <= '0;
         ir_q     <= '0;
      end else if (enable_execute) begin
         aluout_q <= aluout_d;
         pcout_q  <= pcout_d;
         wctl_q   <= W_Control_in;
         dr_q     <= IR[11:9];
         mdata_q  <= r2;
         ir_q     <= IR;
      end
   end

   assign aluout        = aluout_q;
   assign pcout         = pcout_q;
   assign W_Control_out = wctl_q;
   assign dr            = dr_q;
   assign M_Data        = mdata_q;
   assign IR_Exec       = ir_q;

endmodule

// File: doc/lc3_execute.md
# lc3_execute

Execute stage of the LC-3 pipeline, directly downstream of decode. It consumes the decoded instruction word, the incremented PC and the E/W control fields. It computes the ALU result (ADD/AND/NOT) and the PC-relative address (LEA/branch/memory), with operand forwarding from the execute and memory stages. All results are registered for the writeback/memory stages.

## Interface

Parameters:
- none (datapath fixed at 16 bits, register index fixed at 3 bits)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- enable_execute  in  1  advance enable; outputs hold when low
- IR  in  16  instruction from decode
- npc_in  in  16  PC+1 from decode
- E_Control  in  6  [5:4] alu_control, [3:2] pcselect1, [1] pcselect2, [0] op2select
- W_Control_in  in  2  writeback select from decode
- VSR1  in  16  register file value at sr1
- VSR2  in  16  register file value at sr2
- bypass_alu_1, bypass_alu_2  in  1  forward registered aluout to operand 1 / operand 2
- bypass_mem_1, bypass_mem_2  in  1  forward Mem_Bypass_Val to operand 1 / operand 2
- Mem_Bypass_Val  in  16  value from memory stage
- aluout  out  16  registered ALU result
- pcout  out  16  registered address result
- W_Control_out  out  2  registered W_Control_in
- dr  out  3  registered IR[11:9]
- M_Data  out  16  registered store data (forwarded operand-2 register value)
- IR_Exec  out  16  registered IR
- sr1  out  3  combinational IR[8:6]
- sr2  out  3  combinational IR[2:0]

## Operation

- Operand 1 (op1): bypass_alu_1 selects aluout; otherwise bypass_mem_1 selects Mem_Bypass_Val; otherwise VSR1. ALU bypass has priority when both are asserted.
- Register operand 2 (r2): same priority scheme using bypass_alu_2, bypass_mem_2 and VSR2.
- ALU operand 2: op2select=1 selects r2. op2select=0 selects imm5, which is IR[4:0] sign-extended.
- alu_control:
  - 00 → op1 + op2
  - 01 → op1 & op2
  - 10 → ~op1
  - 11 → 16'h0000
- All additions are modulo 2^16; carry is discarded.
- pcselect1 (offset):
  - 00 → sext(IR[10:0])
  - 01 → sext(IR[8:0])
  - 10 → sext(IR[5:0])
  - 11 → 16'h0000
- pcselect2 (base): 1 selects npc_in; 0 selects op1 (bypassed).
- pcout next value = base + offset, modulo 2^16.
- Decode encodings this stage must produce correct results for:
  - ADD reg: 000001
  - ADD imm: 000000
  - AND reg: 010001
  - AND imm: 010000
  - NOT: 100000
  - LEA: 000110
- Both aluout and pcout are computed for every instruction. Downstream logic uses W_Control_out to pick one: 00 aluout, 01 memory, 10 pcout.
- sr1 and sr2 are driven combinationally from the current IR so the register file read lands in the same cycle.

## Timing

- On every posedge with rst=1, all registered outputs clear to 0 (aluout, pcout, W_Control_out, dr, M_Data, IR_Exec). This applies regardless of enable_execute.
- On a posedge with rst=0 and enable_execute=1, all registered outputs load from the current inputs. Latency is 1 cycle.
- On a posedge with rst=0 and enable_execute=0, all registered outputs hold their values.
- sr1 and sr2 have zero latency from IR.
- The aluout bypass uses the value registered on the previous cycle. This allows back-to-back dependent ALU instructions with no stall.
- Asserting rst during an enabled cycle clears the outputs. The in-flight instruction is dropped and does not appear after reset is released.
- Bypass inputs are sampled only on enabled edges; their values during held cycles have no effect.

## Test plan

- Reset: hold rst for 2 cycles with nonzero inputs and enable_execute=1 → every registered output is 0. Release rst, apply ADD reg (IR=16'h1042, E=000001, VSR1=5, VSR2=7) → next cycle aluout=12, dr=0.
- Immediate sign-extension and wrap:
  - ADD imm IR=16'h127F (imm5=-1), VSR1=16'h0000 → aluout=16'hFFFF.
  - VSR1=16'hFFFF with imm5=+1 → aluout=16'h0000.
- AND and NOT:
  - AND reg, VSR1=16'hF0F0, VSR2=16'h3C3C → aluout=16'h3030.
  - NOT (E=100000), VSR1=16'h00FF → aluout=16'hFF00.
  - In both cases W_Control_out equals W_Control_in.
- LEA: IR=16'hE1FE (offset9=-2), npc_in=16'h3001, E=000110, W_Control_in=10 → pcout=16'h2FFF, W_Control_out=10.
- Forwarding priority: first cycle aluout=16'h0010. Second cycle: ADD reg with VSR1=1, bypass_alu_1=1, bypass_mem_1=1, Mem_Bypass_Val=16'h0100, VSR2=2 → aluout=16'h0012. Repeat with bypass_alu_1=0 → aluout=16'h0102.
- Stall hold: load one result, then drive enable_execute=0 for 3 cycles while changing all inputs → outputs unchanged. Re-enable → the new result appears one cycle later.
